// File: rtl/vga_timing_generator.sv
// VGA raster timing: divides clk to a pixel-enable strobe and walks the
// (x, y) raster. Sync/active decodes are registered alongside the coordinates.
module vga_timing_generator #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter int   CLK_DIV  = 2,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        pix_en,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [9:0]       x_next;
   logic [9:0]       y_next;
   logic             wrap_x;
   logic             wrap_y;
   logic             hs_next;
   logic             vs_next;
   logic             act_next;

   // Decodes look at the next coordinates so they land in the same cycle as x/y.
   always_comb begin
      div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      wrap_x   = pix_en && (x == X_LAST);
      wrap_y   = wrap_x && (y == Y_LAST);
      x_next   = x;
      y_next   = y;
      if (pix_en) begin
         if (wrap_x) begin
            x_next = '0;
            y_next = wrap_y ? '0 : y + 10'd1;
         end else begin
            x_next = x + 10'd1;
         end
      end
      hs_next  = (x_next >= HS_START) && (x_next < HS_END);
      vs_next  = (y_next >= VS_START) && (y_next < VS_END);
      act_next = (x_next < X_ACT) && (y_next < Y_ACT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         pix_en      <= 1'b0;
         x           <= '0;
         y           <= '0;
         active      <= 1'b1;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         div_cnt     <= div_next;
         pix_en      <= (div_next == DIV_LAST);
         x           <= x_next;
         y           <= y_next;
         active      <= act_next;
         hsync       <= hs_next ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_next ? SYNC_POL : ~SYNC_POL;
         line_start  <= wrap_x;
         frame_start <= wrap_y;
         if (wrap_y) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule
